// File: rtl/spi_miso_tx.sv
// SPI mode-0 slave transmitter for the MISO return path of the key receiver.
// Host pins are oversampled in sys_clk; bytes queue in a TX FIFO and shift out MSB-first.
module spi_miso_tx #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF,
  localparam int        LW         = $clog2(FIFO_DEPTH + 1),
  localparam int        PW         = $clog2(FIFO_DEPTH)
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          SPI_CLK,
  input  logic          _SS,
  output logic          MISO,
  output logic          MISO_oe,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          busy,
  output logic          byte_sent,
  output logic          underrun,
  output logic [LW-1:0] fifo_level
);

  // state | meaning
  // IDLE  | no frame, MISO tri-stated, waiting for _SS to fall
  // LOAD  | one cycle: fetch first byte of the frame from FIFO or IDLE_BYTE
  // SHIFT | counting SCK rises, shifting on falls, reloading after 8 bits
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, state_nxt;

  logic [2:0]    sck_sync, ss_sync;
  logic          sck_rise, sck_fall, ss_rise, ss_fall;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, load, fifo_empty;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;

  // bits [1:0] synchronize, bit [2] holds the previous synced value for edge detect
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sck_sync <= 3'b111;
      ss_sync  <= 3'b111;
    end else begin
      sck_sync <= {sck_sync[1:0], SPI_CLK};
      ss_sync  <= {ss_sync[1:0], _SS};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign ss_fall  = ~ss_sync[1] & ss_sync[2];

  assign fifo_empty = (fifo_level == '0);
  assign tx_ready   = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  assign load       = ((state == LOAD) | ((state == SHIFT) & sck_fall & (bit_cnt == 4'd8)))
                      & ~ss_rise;
  assign pop        = load & ~fifo_empty;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD:    state_nxt = ss_rise ? IDLE : SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // an _SS rise masks any SCK strobe in the same cycle
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_sent <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      byte_sent <= 1'b0;
      underrun  <= load & fifo_empty;
      if (load) begin
        shreg   <= fifo_empty ? IDLE_BYTE : mem[rd_ptr];
        bit_cnt <= '0;
      end else if ((state == SHIFT) && !ss_rise && (bit_cnt < 4'd8)) begin
        if (sck_rise) begin
          bit_cnt   <= bit_cnt + 4'd1;
          byte_sent <= (bit_cnt == 4'd7);
        end else if (sck_fall) begin
          shreg <= {shreg[6:0], 1'b0};
        end
      end
    end
  end

  assign MISO    = shreg[7];
  assign busy    = (state != IDLE);
  assign MISO_oe = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_spi_miso_tx.sv
// Directed bench for spi_miso_tx: a host model clocks frames, a monitor
// assembles received bytes and checks them against a queue of expected bytes.
module tb_spi_miso_tx;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       ss_n = 1'b1;
  logic       miso, miso_oe;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, byte_sent, underrun;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int bs_cnt = 0, ur_cnt = 0, exp_bs = 0, exp_ur = 0;
  logic bs_prev = 1'b0, ur_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] hbyte = '0;
  int hcnt = 0;

  spi_miso_tx #(.FIFO_DEPTH(16), .IDLE_BYTE(8'hFF)) dut (
    .sys_clk(sys_clk), .rst(rst), .SPI_CLK(spi_clk), ._SS(ss_n),
    .MISO(miso), .MISO_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .byte_sent(byte_sent), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  // nbits SCK pulses; if finish, _SS rises together with the last SCK fall
  task automatic frame(input int nbits, input bit finish);
    ss_n = 1'b0;
    cyc(8);
    check("busy_in_frame", busy, 1'b1);
    check("oe_in_frame", miso_oe, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b1;
      cyc(5);
      spi_clk = 1'b0;
      if (finish && i == nbits - 1) ss_n = 1'b1;
      cyc(5);
    end
    if (finish) cyc(6);
  endtask

  // host side: sample MISO on SCK rise, drop partial bytes when _SS rises
  always @(posedge spi_clk or posedge ss_n) begin
    if (ss_n) begin
      hcnt = 0;
    end else begin
      check("oe_at_sample", miso_oe, 1'b1);
      hbyte = {hbyte[6:0], miso};
      hcnt++;
      if (hcnt == 8) begin
        hcnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", hbyte);
        end else begin
          check("miso_byte", hbyte, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (byte_sent) begin
      bs_cnt++;
      check("byte_sent_width", bs_prev, 1'b0);
    end
    if (underrun) begin
      ur_cnt++;
      check("underrun_width", ur_prev, 1'b0);
    end
    bs_prev = byte_sent;
    ur_prev = underrun;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    cyc(2);
    check("rst_miso", miso, 1'b0);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_byte_sent", byte_sent, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_level", fifo_level, 5'd0);
    rst = 1'b0;
    cyc(2);

    // 2: single byte
    push(8'hA5);
    check("t2_level_1", fifo_level, 5'd1);
    exp_q.push_back(8'hA5);
    exp_bs += 1;
    frame(8, 1'b1);
    check("t2_level_0", fifo_level, 5'd0);
    check("t2_byte_sent", bs_cnt, exp_bs);
    check("t2_idle_oe", miso_oe, 1'b0);
    check("t2_idle_busy", busy, 1'b0);

    // 3: two bytes back-to-back in one frame
    push(8'h3C);
    push(8'hC3);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    exp_bs += 2;
    frame(16, 1'b1);
    check("t3_byte_sent", bs_cnt, exp_bs);
    check("t3_no_underrun", ur_cnt, exp_ur);
    check("t3_level", fifo_level, 5'd0);

    // 4: empty FIFO gives IDLE_BYTE and one underrun
    exp_q.push_back(8'hFF);
    exp_bs += 1;
    exp_ur += 1;
    frame(8, 1'b1);
    check("t4_underrun", ur_cnt, exp_ur);
    check("t4_byte_sent", bs_cnt, exp_bs);

    // 5: overfill
    tx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'h10 + 8'(i);
      if (i == 16) begin
        check("t5_full_ready", tx_ready, 1'b0);
        check("t5_full_level", fifo_level, 5'd16);
      end
      cyc(1);
    end
    tx_valid = 1'b0;
    check("t5_level_after_17", fifo_level, 5'd16);
    exp_q.push_back(8'h10);
    exp_bs += 1;
    frame(8, 1'b1);
    check("t5_level_15", fifo_level, 5'd15);
    check("t5_ready_again", tx_ready, 1'b1);
    do_reset();
    check("t5_reset_level", fifo_level, 5'd0);

    // 6: aborted frame discards partial byte
    push(8'h81);
    push(8'h42);
    frame(3, 1'b0);
    ss_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    check("t6_oe_dropped", miso_oe, 1'b0);
    cyc(4);
    check("t6_no_byte_sent", bs_cnt, exp_bs);
    check("t6_level", fifo_level, 5'd1);
    exp_q.push_back(8'h42);
    exp_bs += 1;
    frame(8, 1'b1);
    check("t6_byte_sent", bs_cnt, exp_bs);
    check("t6_level_0", fifo_level, 5'd0);
    check("t6_underrun_total", ur_cnt, exp_ur);
    check("all_bytes_received", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
